// File: rtl/uart_tx_engine.sv
// UART transmit engine: 8N1/8O1/8E1 framing, LSB first,
// bit period chosen per frame from four baud divisors.
module uart_tx_engine #(
  parameter int unsigned DIV_B0 = 5208,
  parameter int unsigned DIV_B1 = 2604,
  parameter int unsigned DIV_B2 = 1302,
  parameter int unsigned DIV_B3 = 434,
  parameter int unsigned CNT_W  = 16
) (
  input  logic       PCLK,
  input  logic       PRESETn,
  input  logic       send,
  input  logic [7:0] DATA_TX,
  input  logic [1:0] parity_type,
  input  logic [1:0] baud_rate,
  output logic       TX,
  output logic       tx_active_flag,
  output logic       tx_done_flag
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [CNT_W-1:0] div_l, div_l_n, div_sel;
  logic [2:0]       idx, idx_n;
  logic [7:0]       shift_reg, shift_n;
  logic [1:0]       par_l, par_l_n;
  logic             par_bit, par_bit_n;
  logic             par_en;
  logic             send_d;
  logic             start;
  logic             bit_end;
  logic             tx_n;
  logic             done_n;

  always_comb begin
    div_sel = CNT_W'(DIV_B0);
    unique case (1'b1)
      baud_rate == 2'b01: div_sel = CNT_W'(DIV_B1);
      baud_rate == 2'b10: div_sel = CNT_W'(DIV_B2);
      baud_rate == 2'b11: div_sel = CNT_W'(DIV_B3);
      default:            div_sel = CNT_W'(DIV_B0);
    endcase
  end

  assign start   = send & ~send_d & (state == IDLE);
  assign bit_end = (cnt == div_l - 1'b1);
  assign par_en  = ^par_l;

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    idx_n     = idx;
    shift_n   = shift_reg;
    div_l_n   = div_l;
    par_l_n   = par_l;
    par_bit_n = par_bit;
    done_n    = tx_done_flag;
    if (start) begin
      state_n   = START;
      cnt_n     = '0;
      idx_n     = '0;
      shift_n   = DATA_TX;
      div_l_n   = div_sel;
      par_l_n   = parity_type;
      par_bit_n = (parity_type == 2'b01) ? ~^DATA_TX : ^DATA_TX;
      done_n    = 1'b0;
    end else if (state != IDLE) begin
      if (!bit_end) begin
        cnt_n = cnt + 1'b1;
      end else begin
        cnt_n = '0;
        unique case (state)
          START: state_n = DATA;
          DATA: begin
            shift_n = shift_reg >> 1;
            idx_n   = idx + 1'b1;
            if (idx == 3'd7) begin
              state_n = par_en ? PARITY : STOP;
            end
          end
          PARITY: state_n = STOP;
          STOP: begin
            state_n = IDLE;
            done_n  = 1'b1;
          end
          default: state_n = IDLE;
        endcase
      end
    end
  end

  // Line level is registered from the next state, so TX has no input path.
  always_comb begin
    tx_n = 1'b1;
    unique case (state_n)
      START:   tx_n = 1'b0;
      DATA:    tx_n = shift_n[0];
      PARITY:  tx_n = par_bit_n;
      default: tx_n = 1'b1;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state          <= IDLE;
      cnt            <= '0;
      idx            <= '0;
      shift_reg      <= '0;
      div_l          <= '0;
      par_l          <= '0;
      par_bit        <= 1'b0;
      send_d         <= 1'b0;
      TX             <= 1'b1;
      tx_active_flag <= 1'b0;
      tx_done_flag   <= 1'b0;
    end else begin
      state          <= state_n;
      cnt            <= cnt_n;
      idx            <= idx_n;
      shift_reg      <= shift_n;
      div_l          <= div_l_n;
      par_l          <= par_l_n;
      par_bit        <= par_bit_n;
      send_d         <= send;
      TX             <= tx_n;
      tx_active_flag <= (state_n != IDLE);
      tx_done_flag   <= done_n;
    end
  end

endmodule

// File: tb/tb_uart_tx_engine.sv
// Bench for uart_tx_engine: stimulus queues expected frames,
// a line monitor decodes TX and checks every bit period.
module tb_uart_tx_engine;

  logic       PCLK = 1'b0;
  logic       PRESETn = 1'b1;
  logic       send = 1'b0;
  logic [7:0] DATA_TX = 8'h00;
  logic [1:0] parity_type = 2'b00;
  logic [1:0] baud_rate = 2'b11;
  logic       TX;
  logic       tx_active_flag;
  logic       tx_done_flag;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] data;
    logic       par_en;
    logic       par_bit;
    int         div;
    bit         abort;
  } exp_t;

  exp_t exp_q[$];

  uart_tx_engine #(
    .DIV_B0(6),
    .DIV_B1(5),
    .DIV_B2(3),
    .DIV_B3(4),
    .CNT_W (16)
  ) dut (
    .PCLK          (PCLK),
    .PRESETn       (PRESETn),
    .send          (send),
    .DATA_TX       (DATA_TX),
    .parity_type   (parity_type),
    .baud_rate     (baud_rate),
    .TX            (TX),
    .tx_active_flag(tx_active_flag),
    .tx_done_flag  (tx_done_flag)
  );

  always #5 PCLK = ~PCLK;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  function automatic int div_of(input logic [1:0] b);
    case (b)
      2'b00:   return 6;
      2'b01:   return 5;
      2'b10:   return 3;
      default: return 4;
    endcase
  endfunction

  // Monitor: first sample of the frame is the caller's TX==0 sample.
  task automatic check_frame(input exp_t e);
    logic [10:0] bits;
    int          n;
    bit          ok;
    logic        got;
    bits = '1;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[i+1] = e.data[i];
    n = 9;
    if (e.par_en) begin
      bits[9] = e.par_bit;
      n = 10;
    end
    bits[n] = 1'b1;
    n++;
    for (int b = 0; b < n; b++) begin
      ok = 1'b1;
      got = bits[b];
      for (int s = 0; s < e.div; s++) begin
        if (!(b == 0 && s == 0)) @(negedge PCLK);
        if (!PRESETn) begin
          checks++;
          if (!e.abort) begin
            errors++;
            $display("FAIL frame_abort: got reset mid-frame %0h expected full frame",
                     e.data);
          end
          return;
        end
        if (TX !== bits[b] || tx_active_flag !== 1'b1) begin
          ok = 1'b0;
          got = TX;
        end
      end
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL frame_bit: data %0h bit %0d got %b expected %b for %0d cycles",
                 e.data, b, got, bits[b], e.div);
      end
    end
    @(negedge PCLK);
    chk("frame_end", {TX, tx_active_flag, tx_done_flag}, 3'b101);
    if (e.abort) begin
      checks++;
      errors++;
      $display("FAIL frame_abort: got complete frame %0h expected reset abort",
               e.data);
    end
  endtask

  initial begin
    exp_t e;
    int   n;
    forever begin
      @(negedge PCLK);
      if (PRESETn && TX === 1'b0) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_frame: got start bit expected idle line");
          n = 0;
          while (tx_active_flag !== 1'b0 && n < 2000) begin
            @(negedge PCLK);
            n++;
          end
        end else begin
          e = exp_q.pop_front();
          check_frame(e);
        end
      end
    end
  end

  task automatic start_frame(input logic [7:0] d,
                             input logic [1:0] p,
                             input logic [1:0] b,
                             input logic       pb,
                             input bit         abort,
                             input bit         hold);
    exp_t e;
    @(negedge PCLK);
    DATA_TX = d;
    parity_type = p;
    baud_rate = b;
    send = 1'b1;
    e.data = d;
    e.par_en = (p == 2'b01 || p == 2'b10);
    e.par_bit = pb;
    e.div = div_of(b);
    e.abort = abort;
    exp_q.push_back(e);
    @(posedge PCLK);
    #1;
    chk("start_tx", TX, 0);
    chk("start_active", tx_active_flag, 1);
    chk("start_done", tx_done_flag, 0);
    if (!hold) begin
      @(negedge PCLK);
      send = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (tx_active_flag !== 1'b0 && n < 2000) begin
      @(negedge PCLK);
      n++;
    end
    chk("idle_timeout", tx_active_flag, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #2;
    PRESETn = 1'b0;
    repeat (3) @(negedge PCLK);
    chk("rst_tx", TX, 1);
    chk("rst_active", tx_active_flag, 0);
    chk("rst_done", tx_done_flag, 0);
    PRESETn = 1'b1;
    repeat (3) @(negedge PCLK);
    chk("idle_tx", TX, 1);

    // 8N1 0xA5 at div 4
    start_frame(8'hA5, 2'b00, 2'b11, 1'b0, 0, 0);
    wait_idle();
    repeat (10) @(negedge PCLK);
    chk("done_sticky", tx_done_flag, 1);

    // parity: 0x03 even -> 0, odd -> 1; 11 means none
    start_frame(8'h03, 2'b10, 2'b11, 1'b0, 0, 0);
    wait_idle();
    start_frame(8'h03, 2'b01, 2'b11, 1'b1, 0, 0);
    wait_idle();
    start_frame(8'h5A, 2'b11, 2'b11, 1'b0, 0, 0);
    wait_idle();

    // held send, inputs change mid-frame
    start_frame(8'h3C, 2'b00, 2'b11, 1'b0, 0, 1);
    repeat (10) @(negedge PCLK);
    DATA_TX = 8'hFF;
    parity_type = 2'b01;
    baud_rate = 2'b00;
    wait_idle();
    repeat (20) @(negedge PCLK);
    chk("no_retrigger", tx_active_flag, 0);
    send = 1'b0;

    // edges in DATA and in the last STOP cycle are dropped
    start_frame(8'h96, 2'b00, 2'b11, 1'b0, 0, 0);
    repeat (12) @(posedge PCLK);
    @(negedge PCLK);
    send = 1'b1;
    @(negedge PCLK);
    send = 1'b0;
    repeat (26) @(posedge PCLK);
    @(negedge PCLK);
    send = 1'b1;
    @(posedge PCLK);
    #1;
    chk("stop_edge_tx", TX, 1);
    chk("stop_edge_active", tx_active_flag, 0);
    chk("stop_edge_done", tx_done_flag, 1);
    @(negedge PCLK);
    send = 1'b0;
    start_frame(8'hC3, 2'b01, 2'b11, 1'b1, 0, 0);
    wait_idle();

    // reset during DATA
    start_frame(8'hE7, 2'b00, 2'b11, 1'b0, 1, 0);
    repeat (8) @(posedge PCLK);
    #2;
    PRESETn = 1'b0;
    #1;
    chk("abort_tx", TX, 1);
    chk("abort_active", tx_active_flag, 0);
    chk("abort_done", tx_done_flag, 0);
    repeat (2) @(negedge PCLK);
    PRESETn = 1'b1;
    @(negedge PCLK);
    chk("post_rst_tx", TX, 1);
    start_frame(8'h81, 2'b10, 2'b11, 1'b0, 0, 0);
    wait_idle();

    // other divisors
    start_frame(8'h4B, 2'b00, 2'b00, 1'b0, 0, 0);
    wait_idle();
    start_frame(8'h2D, 2'b10, 2'b01, 1'b0, 0, 0);
    wait_idle();
    start_frame(8'h71, 2'b01, 2'b10, 1'b1, 0, 0);
    wait_idle();

    repeat (5) @(negedge PCLK);
    chk("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
